// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ byte producers share one UART transmitter,
// with optional inter-frame gap and a watchdog on transmitter completion.
`timescale 1ns/1ps

module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int GAP_CYCLES     = 0,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_done,
   output logic                 busy,
   output logic [2:0]           owner,
   output logic                 done_pulse,
   output logic                 timeout_err
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT,
      GAP
   } state_t;

   localparam state_t AFTER_FRAME = (GAP_CYCLES > 0) ? GAP : IDLE;

   state_t           state;
   state_t           state_next;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] grant_idx;
   logic [IDX_W-1:0] cand;
   logic             grant_found;
   logic [TO_W-1:0]  to_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic             tx_done_q;
   logic             completion;
   logic             to_hit;

   // Only a rising edge of tx_done completes a frame, so a level left high
   // from the previous frame cannot complete the next one.
   assign completion = tx_done & ~tx_done_q;
   assign to_hit     = (to_cnt == TO_LAST);
   assign busy       = (state != IDLE);

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      state_next  = state;
      req_ready   = '0;
      tx_start    = 1'b0;
      done_pulse  = 1'b0;
      timeout_err = 1'b0;
      unique case (state)
         IDLE: begin
            // rst gates the handshake: a byte must not be consumed while the
            // registers that would latch it are held in reset.
            if (grant_found && !rst) begin
               req_ready[grant_idx] = 1'b1;
               state_next           = START;
            end
         end
         START: begin
            tx_start   = 1'b1;
            state_next = WAIT;
         end
         WAIT: begin
            if (completion) begin
               done_pulse = 1'b1;
               state_next = AFTER_FRAME;
            end else if (to_hit) begin
               timeout_err = 1'b1;
               state_next  = AFTER_FRAME;
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) tx_done_q <= 1'b0;
      else     tx_done_q <= tx_done;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr  <= '0;
         tx_data <= '0;
         owner   <= '0;
      end else if (state == IDLE && grant_found) begin
         tx_data <= req_data[8*grant_idx +: 8];
         owner   <= 3'(grant_idx);
         rr_ptr  <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt  <= '0;
         gap_cnt <= '0;
      end else begin
         if (state == START)     to_cnt <= '0;
         else if (state == WAIT) to_cnt <= to_cnt + 1'b1;

         if (state == WAIT)     gap_cnt <= '0;
         else if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
      end
   end

endmodule
